// File: rtl/pkt_deq_drain.sv
// pkt_deq_drain: egress drain for the packet scheduler dequeue side.
// Pulls scheduler responses into a small FIFO and forwards them downstream over
// valid/ready, gated by link credits. Define DRAIN_PACE_EN to compile in the
// inter-packet GAP state that idles PACE_GAP cycles after every handshake.
module pkt_deq_drain #(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CREDIT_MAX = 8,
    parameter int unsigned PACE_GAP   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sch_valid,
    input  logic [DWIDTH-1:0]                sch_data,
    output logic                             sch_deque_en,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic [DWIDTH-1:0]                tx_data,
    input  logic                             credit_ret,
    output logic [$clog2(CREDIT_MAX+1)-1:0]  credit_cnt,
    output logic [31:0]                      pkt_cnt,
    output logic                             proto_err
);
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned OW  = CW + 1;
    localparam int unsigned CRW = $clog2(CREDIT_MAX + 1);
`ifdef DRAIN_PACE_EN
    localparam int unsigned GW  = (PACE_GAP > 0) ? $clog2(PACE_GAP + 1) : 1;
`endif

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     fifo_count_q, fifo_count_d;
    logic [OW-1:0]     occupancy;
    logic [CRW-1:0]    credit_d;
    logic              inflight_q;
    logic              armed_q;
    logic              wr_en, hs, go_send;
    state_e            state_q, state_d;
`ifdef DRAIN_PACE_EN
    logic [GW-1:0]     gap_q, gap_d;
`endif

    // Outstanding permit plus buffered entries must fit; a same-cycle pop is not credited.
    assign occupancy    = OW'(fifo_count_q) + OW'(inflight_q);
    assign sch_deque_en = rst && (occupancy < OW'(FIFO_DEPTH));
    assign wr_en        = sch_valid && inflight_q;
    assign tx_valid     = (state_q == StSend);
    assign tx_data      = tx_valid ? mem[rd_ptr_q] : '0;
    assign hs           = tx_valid && tx_ready;
    assign fifo_count_d = fifo_count_q + CW'(wr_en) - CW'(hs);
    // Look ahead at next-cycle occupancy/credit so a write reaches tx_valid one edge later.
    assign go_send      = (fifo_count_d != '0) && (credit_d != '0);

    // Credit next-state: return and handshake in the same cycle cancel out.
    always_comb begin
        credit_d = credit_cnt;
        if (credit_ret && !hs) begin
            if (credit_cnt != CRW'(CREDIT_MAX)) begin
                credit_d = credit_cnt + CRW'(1);
            end
        end else if (hs && !credit_ret) begin
            credit_d = credit_cnt - CRW'(1);
        end
    end

    // TX state machine next-state.
    always_comb begin
        state_d = state_q;
`ifdef DRAIN_PACE_EN
        gap_d   = gap_q;
`endif
        unique case (state_q)
            StIdle: state_d = go_send ? StSend : StIdle;
            StSend: begin
                if (hs) begin
`ifdef DRAIN_PACE_EN
                    if (PACE_GAP > 0) begin
                        state_d = StGap;
                        gap_d   = GW'(PACE_GAP);
                    end else begin
                        state_d = go_send ? StSend : StIdle;
                    end
`else
                    state_d = go_send ? StSend : StIdle;
`endif
                end
            end
            StGap: begin
`ifdef DRAIN_PACE_EN
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) begin
                    state_d = go_send ? StSend : StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Control, pointer, counter and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            inflight_q   <= 1'b0;
            armed_q      <= 1'b0;
            credit_cnt   <= CRW'(CREDIT_MAX);
            pkt_cnt      <= '0;
            proto_err    <= 1'b0;
`ifdef DRAIN_PACE_EN
            gap_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fifo_count_q <= fifo_count_d;
            inflight_q   <= sch_deque_en;
            armed_q      <= 1'b1;
            credit_cnt   <= credit_d;
`ifdef DRAIN_PACE_EN
            gap_q        <= gap_d;
`endif
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (hs) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                pkt_cnt  <= pkt_cnt + 32'd1;
            end
            // Unsolicited response; the first cycle after reset release is exempt.
            if (sch_valid && !inflight_q && armed_q) begin
                proto_err <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_ptr_q] <= sch_data;
        end
    end

endmodule

// File: tb/tb_pkt_deq_drain.sv
// Directed bench for pkt_deq_drain with an emulated scheduler that answers every permit.
module tb_pkt_deq_drain;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CMAX  = 8;
    localparam int unsigned GAP   = 2;
`ifdef DRAIN_PACE_EN
    localparam int EXP_DELTA = GAP + 1;
    localparam int MIN_HS    = 4;
`else
    localparam int EXP_DELTA = 1;
    localparam int MIN_HS    = 14;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sch_valid = 1'b0;
    logic [DW-1:0] sch_data = '0;
    logic          sch_deque_en;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] tx_data;
    logic          credit_ret = 1'b0;
    logic [3:0]    credit_cnt;
    logic [31:0]   pkt_cnt;
    logic          proto_err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic        sched_on = 1'b0;
    logic        force_valid = 1'b0;
    logic [31:0] force_data = '0;
    logic        prev_deq = 1'b0;
    logic [31:0] seq = '0;
    int          cyc = 0;
    int          first_wr_cyc = -1;
    int          hs_total = 0;
    int          occ = 0;
    bit          overflow_seen = 1'b0;
    logic [31:0] tx_log[$];
    int          hs_cyc[$];

    pkt_deq_drain #(
        .DWIDTH     (DW),
        .FIFO_DEPTH (DEPTH),
        .CREDIT_MAX (CMAX),
        .PACE_GAP   (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sch_valid    (sch_valid),
        .sch_data     (sch_data),
        .sch_deque_en (sch_deque_en),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .credit_ret   (credit_ret),
        .credit_cnt   (credit_cnt),
        .pkt_cnt      (pkt_cnt),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // One clock: drive inputs, observe at negedge, return just after the next posedge.
    task automatic cycle();
        logic wr, hs;
        if (force_valid) begin
            sch_valid = 1'b1;
            sch_data  = force_data;
        end else begin
            sch_valid = sched_on & prev_deq;
            sch_data  = seq;
        end
        @(negedge clk);
        wr = sch_valid && prev_deq && rst;
        hs = tx_valid && tx_ready && rst;
        if (wr && occ == DEPTH && !hs) overflow_seen = 1'b1;
        if (wr && first_wr_cyc < 0) first_wr_cyc = cyc;
        if (sch_valid && !force_valid) seq = seq + 32'd1;
        if (hs) begin
            tx_log.push_back(tx_data);
            hs_cyc.push_back(cyc);
            hs_total++;
        end
        occ = occ + (wr ? 1 : 0) - (hs ? 1 : 0);
        if (!rst) occ = 0;
        prev_deq = sch_deque_en;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cycle();
        cycle();
        n_checks++; if (sch_deque_en !== 1'b0) begin n_fail++; $display("FAIL reset_deque_en: got %0b exp 0", sch_deque_en); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %0b exp 0", tx_valid); end
        n_checks++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h exp 0", tx_data); end
        n_checks++; if (credit_cnt !== 4'd8) begin n_fail++; $display("FAIL reset_credit: got %0d exp 8", credit_cnt); end
        n_checks++; if (pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d exp 0", pkt_cnt); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %0b exp 0", proto_err); end
        rst = 1'b1;
        #1;
        n_checks++; if (sch_deque_en !== 1'b1) begin n_fail++; $display("FAIL release_deque_en: got %0b exp 1", sch_deque_en); end
    endtask

    task automatic test_credit_exhaust();
        sched_on = 1'b1;
        seq      = 32'h114;
        tx_ready = 1'b1;
        repeat (30) cycle();
        n_checks++; if (tx_log.size() != 8) begin n_fail++; $display("FAIL exhaust_count: got %0d exp 8", tx_log.size()); end
        for (int i = 0; i < tx_log.size() && i < 8; i++) begin
            n_checks++; if (tx_log[i] !== 32'h114 + i) begin n_fail++; $display("FAIL exhaust_data[%0d]: got %h exp %h", i, tx_log[i], 32'h114 + i); end
        end
        n_checks++; if (credit_cnt !== 4'd0) begin n_fail++; $display("FAIL exhaust_credit: got %0d exp 0", credit_cnt); end
        n_checks++; if (pkt_cnt !== 32'd8) begin n_fail++; $display("FAIL exhaust_pkt_cnt: got %0d exp 8", pkt_cnt); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL exhaust_tx_valid: got %0b exp 0", tx_valid); end
        n_checks++; if (sch_deque_en !== 1'b0) begin n_fail++; $display("FAIL exhaust_deque_en: got %0b exp 0", sch_deque_en); end
        if (hs_cyc.size() >= 1) begin
            n_checks++; if (hs_cyc[0] - first_wr_cyc != 1) begin n_fail++; $display("FAIL latency: got %0d exp 1", hs_cyc[0] - first_wr_cyc); end
        end
        if (hs_cyc.size() >= 8) begin
            n_checks++; if (hs_cyc[7] - hs_cyc[0] != 7 * EXP_DELTA) begin n_fail++; $display("FAIL exhaust_spacing: got %0d exp %0d", hs_cyc[7] - hs_cyc[0], 7 * EXP_DELTA); end
        end
    endtask

    task automatic test_credit_return_one();
        credit_ret = 1'b1;
        cycle();
        credit_ret = 1'b0;
        repeat (8) cycle();
        n_checks++; if (tx_log.size() != 9) begin n_fail++; $display("FAIL ret_one_count: got %0d exp 9", tx_log.size()); end
        if (tx_log.size() >= 9) begin
            n_checks++; if (tx_log[8] !== 32'h11C) begin n_fail++; $display("FAIL ret_one_data: got %h exp 11c", tx_log[8]); end
        end
        n_checks++; if (credit_cnt !== 4'd0) begin n_fail++; $display("FAIL ret_one_credit: got %0d exp 0", credit_cnt); end
        n_checks++; if (pkt_cnt !== 32'd9) begin n_fail++; $display("FAIL ret_one_pkt_cnt: got %0d exp 9", pkt_cnt); end
    endtask

    task automatic test_credit_saturate();
        tx_ready   = 1'b0;
        credit_ret = 1'b1;
        repeat (10) cycle();
        n_checks++; if (credit_cnt !== 4'd8) begin n_fail++; $display("FAIL sat_credit: got %0d exp 8", credit_cnt); end
        cycle();
        n_checks++; if (credit_cnt !== 4'd8) begin n_fail++; $display("FAIL sat_hold: got %0d exp 8", credit_cnt); end
    endtask

    task automatic test_credit_coincident();
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL coinc_pre_valid: got %0b exp 1", tx_valid); end
        tx_ready   = 1'b1;
        credit_ret = 1'b1;
        cycle();
        tx_ready   = 1'b0;
        credit_ret = 1'b0;
        n_checks++; if (credit_cnt !== 4'd8) begin n_fail++; $display("FAIL coinc_credit: got %0d exp 8", credit_cnt); end
        n_checks++; if (pkt_cnt !== 32'd10) begin n_fail++; $display("FAIL coinc_pkt_cnt: got %0d exp 10", pkt_cnt); end
        if (tx_log.size() >= 10) begin
            n_checks++; if (tx_log[9] !== 32'h11D) begin n_fail++; $display("FAIL coinc_data: got %h exp 11d", tx_log[9]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] head;
        tx_ready   = 1'b0;
        credit_ret = 1'b0;
        head       = 32'h114 + hs_total;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i >= 3) begin
                n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b exp 1", i, tx_valid); end
                n_checks++; if (tx_data !== head) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h exp %h", i, tx_data, head); end
            end
        end
        n_checks++; if (sch_deque_en !== 1'b0) begin n_fail++; $display("FAIL bp_deque_en: got %0b exp 0", sch_deque_en); end
        tx_ready   = 1'b1;
        credit_ret = 1'b1;
        repeat (12) cycle();
        for (int i = 0; i < tx_log.size(); i++) begin
            n_checks++; if (tx_log[i] !== 32'h114 + i) begin n_fail++; $display("FAIL bp_order[%0d]: got %h exp %h", i, tx_log[i], 32'h114 + i); end
        end
        n_checks++; if (credit_cnt !== 4'd8) begin n_fail++; $display("FAIL bp_credit: got %0d exp 8", credit_cnt); end
    endtask

    task automatic test_pacing();
        int start;
        start = hs_cyc.size();
        repeat (15) cycle();
        n_checks++; if (hs_cyc.size() - start < MIN_HS) begin n_fail++; $display("FAIL pace_count: got %0d exp >= %0d", hs_cyc.size() - start, MIN_HS); end
        for (int j = start + 1; j < hs_cyc.size(); j++) begin
            n_checks++; if (hs_cyc[j] - hs_cyc[j-1] != EXP_DELTA) begin n_fail++; $display("FAIL pace_delta[%0d]: got %0d exp %0d", j, hs_cyc[j] - hs_cyc[j-1], EXP_DELTA); end
        end
    endtask

    task automatic test_proto_err();
        int mark;
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_pre: got %0b exp 0", proto_err); end
        tx_ready   = 1'b0;
        credit_ret = 1'b0;
        repeat (8) cycle();
        n_checks++; if (sch_deque_en !== 1'b0) begin n_fail++; $display("FAIL perr_pre_deque: got %0b exp 0", sch_deque_en); end
        force_valid = 1'b1;
        force_data  = 32'hDEAD;
        cycle();
        force_valid = 1'b0;
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %0b exp 1", proto_err); end
        n_checks++; if (pkt_cnt !== 32'(hs_total)) begin n_fail++; $display("FAIL perr_pkt_cnt: got %0d exp %0d", pkt_cnt, hs_total); end
        repeat (3) cycle();
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %0b exp 1", proto_err); end
        mark       = tx_log.size();
        tx_ready   = 1'b1;
        credit_ret = 1'b1;
        repeat (8) cycle();
        for (int i = mark; i < tx_log.size(); i++) begin
            n_checks++; if (tx_log[i] !== 32'h114 + i) begin n_fail++; $display("FAIL perr_order[%0d]: got %h exp %h", i, tx_log[i], 32'h114 + i); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int mark;
        tx_ready   = 1'b0;
        credit_ret = 1'b0;
        sched_on   = 1'b1;
        repeat (8) cycle();
        sched_on = 1'b0;
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        cycle();
        rst      = 1'b0;
        hs_total = 0;
        cycle();
        n_checks++; if (sch_deque_en !== 1'b0) begin n_fail++; $display("FAIL mid_deque_en: got %0b exp 0", sch_deque_en); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_tx_valid: got %0b exp 0", tx_valid); end
        n_checks++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL mid_tx_data: got %h exp 0", tx_data); end
        n_checks++; if (credit_cnt !== 4'd8) begin n_fail++; $display("FAIL mid_credit: got %0d exp 8", credit_cnt); end
        n_checks++; if (pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_pkt_cnt: got %0d exp 0", pkt_cnt); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_proto_err: got %0b exp 0", proto_err); end
        cycle();
        rst = 1'b1;
        #1;
        n_checks++; if (sch_deque_en !== 1'b1) begin n_fail++; $display("FAIL mid_release_deque: got %0b exp 1", sch_deque_en); end
        force_valid = 1'b1;
        force_data  = 32'hBAD;
        cycle();
        force_valid = 1'b0;
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_ignored_valid: got %0b exp 0", proto_err); end
        mark     = tx_log.size();
        sched_on = 1'b1;
        seq      = 32'h200;
        tx_ready = 1'b1;
        repeat (10) cycle();
        n_checks++; if (tx_log.size() <= mark + 1) begin n_fail++; $display("FAIL mid_post_count: got %0d exp > %0d", tx_log.size(), mark + 1); end
        if (tx_log.size() > mark + 1) begin
            n_checks++; if (tx_log[mark] !== 32'h200) begin n_fail++; $display("FAIL mid_first_pkt: got %h exp 200", tx_log[mark]); end
            n_checks++; if (tx_log[mark+1] !== 32'h201) begin n_fail++; $display("FAIL mid_second_pkt: got %h exp 201", tx_log[mark+1]); end
        end
        n_checks++; if (pkt_cnt !== 32'(hs_total)) begin n_fail++; $display("FAIL mid_pkt_cnt_post: got %0d exp %0d", pkt_cnt, hs_total); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_proto_post: got %0b exp 0", proto_err); end
    endtask

    task automatic test_no_overflow();
        n_checks++; if (overflow_seen !== 1'b0) begin n_fail++; $display("FAIL fifo_overflow: got %0b exp 0", overflow_seen); end
    endtask

    initial begin
        test_reset();
        test_credit_exhaust();
        test_credit_return_one();
        test_credit_saturate();
        test_credit_coincident();
        test_backpressure();
        test_pacing();
        test_proto_err();
        test_reset_mid_burst();
        test_no_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
